led_seq: RTL
============

LED_SEQ -- requirements
Module: led_seq

Interface
REQ-001 Parameter WIDTH, default 18, number of LED outputs; legal range 2..32.
REQ-002 Parameter TICK_DIV, default 5000000, CLOCK_50 cycles per pattern step (100 ms at 50 MHz); legal range >= 2.
REQ-003 CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-004 rs  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  1 = run, 0 = freeze tick counter, state and led.
REQ-006 mode  input  2  pattern select: 0 blink, 1 fill wave, 2 bounce, 3 off.
REQ-007 led  output  WIDTH  LED drive, registered, bit 0 = rightmost.
REQ-008 tick  output  1  one-cycle pulse on each pattern step.
REQ-009 wrap  output  1  one-cycle pulse, coincident with tick, on the step completing a pattern period.

Function
REQ-010 Tick counter SHALL count 0..TICK_DIV-1 while en=1, assert tick when at TICK_DIV-1, and then return to 0.
REQ-011 led, pattern state and position counter SHALL change only on cycles with tick=1.
REQ-012 On a tick where mode differs from the latched mode, or on the first tick after reset, the block SHALL latch mode and load the entry pattern: blink all-ones; fill and bounce 0...01; off all-zeros; wrap=0.
REQ-013 Blink: each later tick SHALL invert led between all-ones and all-zeros; wrap on the step to all-zeros; period 2 ticks.
REQ-014 Fill states FILL_UP, CLR_UP, FILL_DN, CLR_DN: FILL_UP shifts led left with 1 in; after all-ones, next tick CLR_UP gives 0; FILL_DN shifts right with 1 into the MSB; after all-ones, CLR_DN gives 0 then returns to FILL_UP.
REQ-015 Fill period SHALL be 2*WIDTH+2 ticks, with wrap on the CLR_DN step.
REQ-016 Bounce: one-hot led SHALL move left to bit WIDTH-1, then right to bit 0, with no repeat at either end; period 2*(WIDTH-1) ticks; wrap on the step returning to bit 0.
REQ-017 Off: led SHALL hold all-zeros; tick continues; wrap never asserts.
REQ-018 Position counter width SHALL be clog2(WIDTH) and SHALL never exceed WIDTH-1.
REQ-019 Mode change mid-period SHALL abandon the current pattern at the next tick with no partial-step artefacts.
REQ-020 en falling SHALL freeze all state exactly; en rising SHALL resume counting from the frozen tick count.

Reset
REQ-021 On any rising edge with rs=0, the block SHALL set led=0, tick=0, wrap=0, tick count 0 and pattern state idle, and SHALL mark latched mode invalid.
REQ-022 Reset SHALL take priority over en and tick, and SHALL take effect mid-pattern at the same edge.

Configuration
REQ-023 With LED_SEQ_CNT_EN defined, the block SHALL add output cyc_cnt[7:0], cleared by reset and by mode change, incremented on each wrap, wrapping 255->0.
REQ-024 Without LED_SEQ_CNT_EN, the cyc_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (WIDTH=4, TICK_DIV=4)
REQ-025 rs=0 for 3 cycles, then rs=1, en=1, mode=1 -> led=0000 until the first tick (cycle 4), then the sequence 0001,0011,0111,1111,0000,1000,1100,1110,1111,0000,0001, with wrap on the 10th step.
REQ-026 mode=2 from reset -> led 0001,0010,0100,1000,0100,0010,0001, with wrap only on the final 0001.
REQ-027 mode=0 -> led 1111,0000,1111 with wrap on each 0000; then mode=3 mid-period -> 0000 at the next tick, and wrap stays 0.
REQ-028 en=0 for 10 cycles mid-fill at led=0011 -> led, tick count and tick frozen; after en=1 the next step 0111 occurs after the remaining tick count.
REQ-029 rs=0 asserted at led=1110 -> led=0000 at that edge; the first tick after release reloads 0001.
REQ-030 With LED_SEQ_CNT_EN, 256 fill periods -> cyc_cnt=0 after wrap-around; a mode change clears cyc_cnt to 0.

Source files
------------

// File: rtl/led_seq.sv
// led_seq: timed LED pattern sequencer (blink, fill wave, bounce, off).
// Define LED_SEQ_CNT_EN to add the cyc_cnt completed-period counter output.
module led_seq #(
  parameter int WIDTH    = 18,
  parameter int TICK_DIV = 5000000
) (
  input  logic             CLOCK_50,
  input  logic             rs,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             wrap
`ifdef LED_SEQ_CNT_EN
  ,
  output logic [7:0]       cyc_cnt
`endif
);
  localparam int CW = $clog2(TICK_DIV);
  localparam int PW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  typedef enum logic [3:0] {IDLE, BLINK, FILL_UP, CLR_UP, FILL_DN, CLR_DN, BNC_UP, BNC_DN, OFF} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [PW-1:0] pos, pos_n;
  logic [1:0] lmode;
  logic [WIDTH-1:0] led_n;
  logic wrap_n, step, load;
  assign step = en && cnt == CW'(TICK_DIV - 1);
  // IDLE doubles as "latched mode invalid", forcing a reload on the first tick
  assign load = state == IDLE || mode != lmode;
  always_comb begin
    state_n = state;
    led_n = led;
    pos_n = pos;
    wrap_n = 1'b0;
    if (load) begin
      pos_n = '0;
      led_n = mode == 2'd0 ? ONES : mode == 2'd3 ? '0 : ONE;
      state_n = mode == 2'd0 ? BLINK : mode == 2'd1 ? FILL_UP : mode == 2'd2 ? BNC_UP : OFF;
    end else begin
      case (state)
        BLINK: begin
          led_n = ~led;
          wrap_n = led == ONES;
        end
        FILL_UP: begin
          led_n = {led[WIDTH-2:0], 1'b1};
          state_n = &led[WIDTH-2:0] ? CLR_UP : FILL_UP;
        end
        CLR_UP: begin
          led_n = '0;
          state_n = FILL_DN;
        end
        FILL_DN: begin
          led_n = {1'b1, led[WIDTH-1:1]};
          state_n = &led[WIDTH-1:1] ? CLR_DN : FILL_DN;
        end
        CLR_DN: begin
          led_n = '0;
          wrap_n = 1'b1;
          state_n = FILL_UP;
        end
        BNC_UP: begin
          pos_n = pos + 1'b1;
          led_n = ONE << pos_n;
          state_n = pos_n == PW'(WIDTH - 1) ? BNC_DN : BNC_UP;
        end
        BNC_DN: begin
          pos_n = pos - 1'b1;
          led_n = ONE << pos_n;
          wrap_n = pos_n == '0;
          state_n = pos_n == '0 ? BNC_UP : BNC_DN;
        end
        default: led_n = '0;
      endcase
    end
  end
  always_ff @(posedge CLOCK_50) begin
    if (!rs) begin
      cnt <= '0;
      tick <= 1'b0;
      wrap <= 1'b0;
      led <= '0;
      pos <= '0;
      lmode <= 2'd0;
      state <= IDLE;
    end else if (en) begin
      cnt <= step ? '0 : cnt + 1'b1;
      tick <= step;
      wrap <= step && wrap_n;
      if (step) begin
        led <= led_n;
        pos <= pos_n;
        lmode <= mode;
        state <= state_n;
      end
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end
  end
`ifdef LED_SEQ_CNT_EN
  always_ff @(posedge CLOCK_50) begin
    if (!rs || (step && load))
      cyc_cnt <= 8'd0;
    else if (step && wrap_n)
      cyc_cnt <= cyc_cnt + 8'd1;
  end
`endif
endmodule
